// File: rtl/proc_io_bridge_if.sv
// Processor IO bus plus the external input/output streams of the IO bridge.
// slave: the bridge side; master: the core/environment side.
interface proc_io_bridge_if #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8
);
    localparam int IAW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int OAW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    // processor side
    logic [IAW-1:0]    addr_in;
    logic              req_in;
    logic [NUBITS-1:0] io_in;
    logic [NUBITS-1:0] io_out;
    logic [OAW-1:0]    addr_out;
    logic              out_en;
    // external input stream
    logic [NUBITS-1:0] ext_in_data;
    logic [IAW-1:0]    ext_in_addr;
    logic              ext_in_valid;
    logic              ext_in_ready;
    // external output stream
    logic [NUBITS-1:0] ext_out_data;
    logic [OAW-1:0]    ext_out_addr;
    logic              ext_out_valid;
    logic              ext_out_ready;
    // status
    logic [NUIOIN-1:0] in_fresh;
    logic              ovf_flag;
    logic              unf_flag;
    logic              clr_flags;

    modport slave (
        input  addr_in, req_in, io_out, addr_out, out_en,
        input  ext_in_data, ext_in_addr, ext_in_valid, ext_out_ready, clr_flags,
        output io_in, ext_in_ready, ext_out_data, ext_out_addr, ext_out_valid,
        output in_fresh, ovf_flag, unf_flag
    );

    modport master (
        output addr_in, req_in, io_out, addr_out, out_en,
        output ext_in_data, ext_in_addr, ext_in_valid, ext_out_ready, clr_flags,
        input  io_in, ext_in_ready, ext_out_data, ext_out_addr, ext_out_valid,
        input  in_fresh, ovf_flag, unf_flag
    );
endinterface

// File: rtl/proc_io_bridge.sv
// Peripheral-side responder for the processor IO bus.
// Input side: per-address holding registers with fresh flags fed by a
// valid/ready stream. Output side: processor writes queued as {addr, data}
// in a FIFO drained to a valid/ready stream.
module proc_io_bridge #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int ODEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    proc_io_bridge_if.slave bus
);
    localparam int IAW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int OAW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
    localparam int PW  = $clog2(ODEPTH);

    // ---------------- input side ----------------
    logic [NUBITS-1:0] hold [NUIOIN];
    logic [NUIOIN-1:0] fresh;
    logic              rd_ok, ld_ok;
    logic              rd_hit, load, unf_set;

    // Range checks only exist when the address space is not fully populated.
    if (NUIOIN == (1 << IAW)) begin : g_in_full
        assign rd_ok = 1'b1;
        assign ld_ok = 1'b1;
    end else begin : g_in_part
        assign rd_ok = (32'(bus.addr_in) < 32'(NUIOIN));
        assign ld_ok = (32'(bus.ext_in_addr) < 32'(NUIOIN));
    end

    assign rd_hit           = bus.req_in && rd_ok;
    assign bus.io_in        = rd_ok ? hold[bus.addr_in] : '0;
    assign bus.ext_in_ready = ld_ok && !fresh[bus.ext_in_addr];
    assign load             = bus.ext_in_valid && bus.ext_in_ready;
    assign unf_set          = rd_hit && !fresh[bus.addr_in];
    assign bus.in_fresh     = fresh;

    // Holding registers: a load to the address being read wins the fresh flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUIOIN; i++) hold[i] <= '0;
            fresh <= '0;
        end else begin
            for (int i = 0; i < NUIOIN; i++) begin
                if (load && bus.ext_in_addr == IAW'(i)) begin
                    hold[i]  <= bus.ext_in_data;
                    fresh[i] <= 1'b1;
                end else if (rd_hit && bus.addr_in == IAW'(i)) begin
                    fresh[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic [OAW+NUBITS-1:0] mem [ODEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic                  full, pop, push, ovf_set;

    assign full              = (count == (PW+1)'(ODEPTH));
    assign bus.ext_out_valid = (count != '0);
    assign pop               = bus.ext_out_valid && bus.ext_out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push              = bus.out_en && (!full || pop);
    assign ovf_set           = bus.out_en && full && !pop;
    assign {bus.ext_out_addr, bus.ext_out_data} = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ODEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= {bus.addr_out, bus.io_out};
        end
    end

    // Pointers wrap naturally at ODEPTH (power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a set event beats a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ovf_flag <= 1'b0;
            bus.unf_flag <= 1'b0;
        end else begin
            if (ovf_set)            bus.ovf_flag <= 1'b1;
            else if (bus.clr_flags) bus.ovf_flag <= 1'b0;
            if (unf_set)            bus.unf_flag <= 1'b1;
            else if (bus.clr_flags) bus.unf_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_proc_io_bridge.sv
// Scoreboard bench for proc_io_bridge: stimulus pushes expected io_in reads and
// expected output-stream words into queues; a negedge monitor pops and compares.
module tb_proc_io_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_io_bridge_if #(.NUBITS(16), .NUIOIN(8), .NUIOOU(8)) bus ();

    proc_io_bridge #(.NUBITS(16), .NUIOIN(8), .NUIOOU(8), .ODEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } out_t;

    logic [15:0] io_q [$];
    out_t        oq [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_out(input logic [2:0] a, input logic [15:0] d);
        out_t e;
        bus.out_en   = 1'b1;
        bus.addr_out = a;
        bus.io_out   = d;
        e.a = a;
        e.d = d;
        oq.push_back(e);
    endtask

    // Monitor: compare every processor read and every output-stream pop.
    always @(negedge clk) begin
        if (bus.req_in) begin
            if (io_q.size() == 0) check("io_unexpected", 32'(bus.io_in), 32'hFFFF_FFFF);
            else check("io_in", 32'(bus.io_in), 32'(io_q.pop_front()));
        end
        if (bus.ext_out_valid && bus.ext_out_ready) begin
            if (oq.size() == 0) begin
                check("out_unexpected", {13'd0, bus.ext_out_addr, bus.ext_out_data}, 32'hFFFF_FFFF);
            end else begin
                out_t e;
                e = oq.pop_front();
                check("out_word", {13'd0, bus.ext_out_addr, bus.ext_out_data}, {13'd0, e.a, e.d});
            end
        end
    end

    initial begin
        bus.addr_in = '0; bus.req_in = 1'b0; bus.io_out = '0; bus.addr_out = '0;
        bus.out_en = 1'b0; bus.ext_in_data = '0; bus.ext_in_addr = 3'd4;
        bus.ext_in_valid = 1'b0; bus.ext_out_ready = 1'b0; bus.clr_flags = 1'b0;
        #12;
        // reset state
        check("rst_out_valid", 32'(bus.ext_out_valid), 0);
        check("rst_out_word", {13'd0, bus.ext_out_addr, bus.ext_out_data}, 0);
        check("rst_io_in", 32'(bus.io_in), 0);
        check("rst_in_ready", 32'(bus.ext_in_ready), 1);
        check("rst_fresh", 32'(bus.in_fresh), 0);
        check("rst_flags", {30'd0, bus.ovf_flag, bus.unf_flag}, 0);
        rst = 1'b0;
        tick();

        // load addr 3, second load blocked, consume
        bus.ext_in_addr = 3'd3; bus.ext_in_data = 16'h1234; bus.ext_in_valid = 1'b1;
        #1 check("load_ready", 32'(bus.ext_in_ready), 1);
        tick();
        bus.ext_in_data = 16'h5555;
        check("fresh3_set", 32'(bus.in_fresh), 32'h08);
        check("load_blocked", 32'(bus.ext_in_ready), 0);
        tick();
        bus.ext_in_valid = 1'b0;
        bus.req_in = 1'b1; bus.addr_in = 3'd3; io_q.push_back(16'h1234);
        tick();
        bus.req_in = 1'b0;
        check("fresh3_clr", 32'(bus.in_fresh), 0);
        check("unf_clean", 32'(bus.unf_flag), 0);

        // stale read, clear, clear vs set
        bus.req_in = 1'b1; bus.addr_in = 3'd5; io_q.push_back(16'h0000);
        tick();
        bus.req_in = 1'b0;
        check("unf_stale", 32'(bus.unf_flag), 1);
        bus.clr_flags = 1'b1;
        tick();
        check("unf_cleared", 32'(bus.unf_flag), 0);
        bus.req_in = 1'b1; bus.addr_in = 3'd5; io_q.push_back(16'h0000);
        tick();
        bus.req_in = 1'b0; bus.clr_flags = 1'b0;
        check("unf_set_wins", 32'(bus.unf_flag), 1);

        // same-cycle read + load on a non-fresh address
        bus.ext_in_addr = 3'd2; bus.ext_in_data = 16'h0011; bus.ext_in_valid = 1'b1;
        tick();
        bus.ext_in_valid = 1'b0;
        bus.req_in = 1'b1; bus.addr_in = 3'd2; io_q.push_back(16'h0011);
        tick();
        bus.req_in = 1'b0; bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        check("unf_pre_same", 32'(bus.unf_flag), 0);
        bus.req_in = 1'b1; bus.addr_in = 3'd2; io_q.push_back(16'h0011);
        bus.ext_in_addr = 3'd2; bus.ext_in_data = 16'h00AA; bus.ext_in_valid = 1'b1;
        #1 check("same_ready", 32'(bus.ext_in_ready), 1);
        tick();
        bus.req_in = 1'b0; bus.ext_in_valid = 1'b0;
        check("same_unf", 32'(bus.unf_flag), 1);
        check("same_fresh", 32'(bus.in_fresh), 32'h04);
        bus.req_in = 1'b1; io_q.push_back(16'h00AA);
        tick();
        bus.req_in = 1'b0; bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;

        // fill, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            push_out(3'(i % 8), 16'(16'h0100 + i));
            tick();
        end
        bus.out_en = 1'b0;
        check("fill_valid", 32'(bus.ext_out_valid), 1);
        check("fill_head", {13'd0, bus.ext_out_addr, bus.ext_out_data}, {13'd0, 3'd1, 16'h0101});
        bus.out_en = 1'b1; bus.addr_out = 3'd0; bus.io_out = 16'hDEAD;
        tick();
        bus.out_en = 1'b0;
        check("ovf_set", 32'(bus.ovf_flag), 1);
        bus.ext_out_ready = 1'b1;
        repeat (8) tick();
        bus.ext_out_ready = 1'b0;
        check("drain_empty", 32'(bus.ext_out_valid), 0);
        check("drain_sb", 32'(oq.size()), 0);

        // empty FIFO: push with ready high, pop ignored
        bus.clr_flags = 1'b1;
        push_out(3'd5, 16'h0555);
        bus.ext_out_ready = 1'b1;
        #1 check("empty_valid0", 32'(bus.ext_out_valid), 0);
        tick();
        bus.out_en = 1'b0; bus.clr_flags = 1'b0;
        check("empty_latency", 32'(bus.ext_out_valid), 1);
        tick();
        bus.ext_out_ready = 1'b0;
        check("empty_after", 32'(bus.ext_out_valid), 0);

        // full FIFO streaming with push and pop together (pointer wrap)
        for (int i = 0; i < 8; i++) begin
            push_out(3'(i), 16'(16'h0200 + i));
            tick();
        end
        bus.ext_out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            push_out(3'(k % 8), 16'(16'h0300 + k));
            tick();
        end
        bus.out_en = 1'b0; bus.ext_out_ready = 1'b0;
        check("stream_no_ovf", 32'(bus.ovf_flag), 0);
        bus.ext_out_ready = 1'b1;
        repeat (8) tick();
        bus.ext_out_ready = 1'b0;
        check("stream_count8", 32'(bus.ext_out_valid), 0);
        check("stream_sb", 32'(oq.size()), 0);

        // reset mid-drain
        bus.ext_in_addr = 3'd1; bus.ext_in_data = 16'h0F0F; bus.ext_in_valid = 1'b1;
        bus.req_in = 1'b1; bus.addr_in = 3'd6; io_q.push_back(16'h0000);
        tick();
        bus.ext_in_valid = 1'b0; bus.req_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_out(3'(i), 16'(16'h0400 + i));
            tick();
        end
        bus.out_en = 1'b0; bus.ext_out_ready = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        oq.delete();
        bus.ext_out_ready = 1'b0;
        check("mid_rst_valid", 32'(bus.ext_out_valid), 0);
        check("mid_rst_fresh", 32'(bus.in_fresh), 0);
        check("mid_rst_flags", {30'd0, bus.ovf_flag, bus.unf_flag}, 0);
        tick();
        rst = 1'b0;
        push_out(3'd2, 16'h0777);
        tick();
        bus.out_en = 1'b0;
        check("post_rst_head", {13'd0, bus.ext_out_addr, bus.ext_out_data}, {13'd0, 3'd2, 16'h0777});
        bus.ext_out_ready = 1'b1;
        tick();
        bus.ext_out_ready = 1'b0;
        check("post_rst_empty", 32'(bus.ext_out_valid), 0);
        check("final_out_sb", 32'(oq.size()), 0);
        check("final_io_sb", 32'(io_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
